nack_sched_rr: RTL and testbench

- Packet-granular round-robin scheduler that shares the single NACK egress path among N NACK-generating channels.
- Each channel presents a multi-beat NACK descriptor on a valid/ready stream.
- The scheduler grants one channel at a time and holds the grant until that channel's last beat has transferred.
- Beats are forwarded through a 2-entry output buffer to the egress stream, tagged with the source channel index.

---
 rtl/nack_sched_pkg.sv | 42 ++++
 rtl/nack_sched_rr_if.sv | 28 ++
 rtl/nack_sched_buf.sv | 57 +++++
 rtl/nack_sched_rr.sv | 109 ++++++++++
 tb/tb_nack_sched_rr.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nack_sched_pkg.sv
// Shared types and the round-robin pick helper for the NACK egress scheduler.
package nack_sched_pkg;

  localparam int unsigned MAX_N  = 16;
  localparam int unsigned MAX_CW = 4;
  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_DW = 64;
  localparam int unsigned DEF_CW = $clog2(DEF_N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef struct packed {
    logic              found;
    logic [MAX_CW-1:0] idx;
  } pick_t;

  typedef struct packed {
    logic [DEF_DW-1:0] data;
    logic              last;
    logic [DEF_CW-1:0] src;
  } buf_entry_t;

  // First requester at or above ptr, else the lowest-index requester.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input logic [MAX_CW-1:0] ptr);
    pick_t hi;
    pick_t lo;
    hi = '0;
    lo = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo.found = 1'b1;
        lo.idx   = MAX_CW'(i);
        if (MAX_CW'(i) >= ptr) begin
          hi.found = 1'b1;
          hi.idx   = MAX_CW'(i);
        end
      end
    end
    return hi.found ? hi : lo;
  endfunction

endpackage

// File: rtl/nack_sched_rr_if.sv
// Channel-side and egress-side stream bundle of the NACK scheduler.
interface nack_sched_rr_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 64
);
  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]    s_valid;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [CW-1:0]   m_src;
  logic            m_ready;
  logic            busy;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_src, busy
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_src, busy
  );
endinterface

// File: rtl/nack_sched_buf.sv
// Two-entry shift FIFO; the head entry is a register that drives the egress directly.
module nack_sched_buf
  import nack_sched_pkg::*;
#(
  parameter type entry_t = buf_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  entry_t     i_entry,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output entry_t     o_head
);

  entry_t     r_head;
  entry_t     r_tail;
  entry_t     w_head_nxt;
  entry_t     w_tail_nxt;
  logic [1:0] r_count;
  logic [1:0] w_count_nxt;
  logic       w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  // Pop shifts tail to head; push lands in the first free slot after the pop.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (w_pop) begin
      w_head_nxt  = r_tail;
      w_count_nxt = r_count - 2'd1;
    end
    if (i_push) begin
      if (w_count_nxt == 2'd0) w_head_nxt = i_entry;
      else                     w_tail_nxt = i_entry;
      w_count_nxt = w_count_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/nack_sched_rr.sv
// Packet-granular round-robin scheduler sharing one NACK egress among N channels.
module nack_sched_rr
  import nack_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 64
) (
  input logic              clk,
  input logic              rst_n,
  nack_sched_rr_if.slave   io
);

  localparam int unsigned CW = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] src;
  } entry_t;

  state_e        r_state;
  logic [CW-1:0] r_grant;
  logic [CW-1:0] r_ptr;
  pick_t         w_pick;
  logic          w_pick_ok;
  logic          w_g_valid;
  logic          w_g_last;
  logic [DW-1:0] w_g_data;
  logic          w_ready;
  logic          w_push;
  logic [N-1:0]  w_s_ready;
  logic [1:0]    w_count;
  logic [CW-1:0] w_ptr_inc;
  entry_t        w_entry;
  entry_t        w_head;

  assign w_pick    = rr_pick(MAX_N'(io.s_valid), MAX_CW'(r_ptr));
  assign w_pick_ok = w_pick.found && (w_pick.idx < MAX_CW'(N));

  // Select the granted channel's beat; other channels' data and last are ignored.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (CW'(i) == r_grant) begin
        w_g_valid = io.s_valid[i];
        w_g_last  = io.s_last[i];
        w_g_data  = io.s_data[i*DW +: DW];
      end
    end
  end

  assign w_ready = (r_state == BUSY) && (w_count != 2'd2);
  assign w_push  = w_ready && w_g_valid;

  always_comb begin
    w_s_ready          = '0;
    w_s_ready[r_grant] = w_ready;
  end

  assign w_ptr_inc = (r_grant == CW'(N - 1)) ? '0 : r_grant + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_ok) begin
            r_grant <= CW'(w_pick.idx);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_push && w_g_last) begin
            r_ptr   <= w_ptr_inc;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_entry.data = w_g_data;
  assign w_entry.last = w_g_last;
  assign w_entry.src  = r_grant;

  nack_sched_buf #(.entry_t(entry_t)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (io.m_ready),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign io.s_ready = w_s_ready;
  assign io.m_valid = (w_count != 2'd0);
  assign io.m_data  = w_head.data;
  assign io.m_last  = w_head.last;
  assign io.m_src   = w_head.src;
  assign io.busy    = (r_state == BUSY);

endmodule

// File: tb/tb_nack_sched_rr.sv
// Randomized scoreboard bench for nack_sched_rr against a transaction-level reference model.
module tb_nack_sched_rr;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] src;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nack_sched_rr_if #(.N(N), .DW(DW)) bus ();
  nack_sched_rr #(.N(N), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  int errors = 0;
  int checks = 0;
  beat_t sb[$];

  // Reference model: grant holder, pointer and buffer occupancy as plain integers.
  bit m_busy;
  int m_g, m_ptr, m_cnt;

  // Per-channel packet sources.
  int rem[N], beat_no[N], pkt_no[N], pkts_left[N];
  logic [DW-1:0] cur_data[N];
  int len_lo, len_hi, vprob, rprob;
  logic [N-1:0] xfer;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] mk(input int ch);
    return {8'(ch), 8'(pkt_no[ch]), 8'(beat_no[ch]), 8'hA5, 32'($urandom)};
  endfunction

  task automatic drive();
    for (int ch = 0; ch < N; ch++) begin
      bit v;
      if (xfer[ch]) begin
        rem[ch]--;
        beat_no[ch]++;
        if (rem[ch] == 0) pkt_no[ch]++;
        cur_data[ch] = mk(ch);
      end
      if (rem[ch] == 0 && pkts_left[ch] > 0) begin
        rem[ch]       = int'($urandom_range(len_hi, len_lo));
        pkts_left[ch] = pkts_left[ch] - 1;
        beat_no[ch]   = 0;
        cur_data[ch]  = mk(ch);
      end
      v = (rem[ch] > 0) && (int'($urandom_range(99)) < vprob);
      bus.s_valid[ch]          = v;
      bus.s_last[ch]           = v ? (rem[ch] == 1) : 1'($urandom);
      bus.s_data[ch*DW +: DW]  = v ? cur_data[ch] : {$urandom, $urandom};
    end
    bus.m_ready = int'($urandom_range(99)) < rprob;
  endtask

  task automatic model_step();
    logic [N-1:0] exp_rdy;
    bit push, pop;
    int w;
    beat_t b;
    exp_rdy = '0;
    if (m_busy && m_cnt < 2) exp_rdy[m_g] = 1'b1;
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("s_ready", 64'(bus.s_ready), 64'(exp_rdy));
    chk("m_valid", 64'(bus.m_valid), 64'(m_cnt > 0));
    xfer = bus.s_valid & bus.s_ready;
    push = m_busy && m_cnt < 2 && bus.s_valid[m_g];
    pop  = m_cnt > 0 && bus.m_ready;
    if (push) begin
      b.data = bus.s_data[m_g*DW +: DW];
      b.last = bus.s_last[m_g];
      b.src  = CW'(m_g);
      sb.push_back(b);
    end
    m_cnt = m_cnt + int'(push) - int'(pop);
    if (!m_busy) begin
      w = pick(bus.s_valid, m_ptr);
      if (w >= 0) begin
        m_g    = w;
        m_busy = 1'b1;
      end
    end else if (push && bus.s_last[m_g]) begin
      m_ptr  = (m_g + 1) % N;
      m_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_step();
  endtask

  task automatic run_phase(input logic [N-1:0] mask, input int npkts, input int lo, input int hi,
                           input int vp, input int rp, input int ncyc);
    for (int ch = 0; ch < N; ch++) pkts_left[ch] = mask[ch] ? npkts : 0;
    len_lo = lo;
    len_hi = hi;
    vprob  = vp;
    rprob  = rp;
    repeat (ncyc) cycle();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int ch = 0; ch < N; ch++) pkts_left[ch] = 0;
    vprob = 100;
    rprob = 100;
    for (int c = 0; c < 500 && !done; c++) begin
      done = (m_cnt == 0) && !m_busy && (sb.size() == 0);
      for (int ch = 0; ch < N; ch++) if (rem[ch] != 0) done = 1'b0;
      if (!done) cycle();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: traffic still pending (sb=%0d cnt=%0d) after cycle budget", sb.size(), m_cnt);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'(0));
    chk({tag, "_m_data"},  64'(bus.m_data),  64'(0));
    chk({tag, "_m_last"},  64'(bus.m_last),  64'(0));
    chk({tag, "_m_src"},   64'(bus.m_src),   64'(0));
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'(0));
    chk({tag, "_busy"},    64'(bus.busy),    64'(0));
  endtask

  task automatic clear_tb_state();
    sb.delete();
    m_busy = 1'b0;
    m_g    = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    xfer   = '0;
    for (int ch = 0; ch < N; ch++) begin
      rem[ch]       = 0;
      beat_no[ch]   = 0;
      pkts_left[ch] = 0;
    end
    bus.s_valid = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each egress transfer and checks stall stability.
  bit    stall;
  beat_t held;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_data", 64'(bus.m_data), 64'(held.data));
        chk("hold_last", 64'(bus.m_last), 64'(held.last));
        chk("hold_src",  64'(bus.m_src),  64'(held.src));
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL egress: unexpected beat data=%h src=%0d, none expected", bus.m_data, bus.m_src);
        end else begin
          e = sb.pop_front();
          chk("m_data", 64'(bus.m_data), 64'(e.data));
          chk("m_last", 64'(bus.m_last), 64'(e.last));
          chk("m_src",  64'(bus.m_src),  64'(e.src));
        end
      end
      stall     = bus.m_valid && !bus.m_ready;
      held.data = bus.m_data;
      held.last = bus.m_last;
      held.src  = bus.m_src;
    end
  end

  initial begin
    bus.s_data = '0;
    clear_tb_state();
    for (int ch = 0; ch < N; ch++) begin
      pkt_no[ch]   = 0;
      cur_data[ch] = '0;
    end
    #2;
    chk_outputs_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, three beats.
    run_phase(4'b0100, 1, 3, 3, 100, 100, 8);
    drain();
    // Fairness with continuous single-beat packets from every channel.
    run_phase(4'b1111, 6, 1, 1, 100, 100, 40);
    drain();
    // Pointer wrap: ch2 then ch0/ch1 only.
    run_phase(4'b0100, 1, 1, 1, 100, 100, 4);
    drain();
    run_phase(4'b0011, 1, 2, 2, 100, 100, 10);
    drain();
    // Backpressure: five beats against a stalled egress, then release.
    run_phase(4'b0010, 1, 5, 5, 100, 0, 12);
    chk("bp_s_ready", 64'(bus.s_ready), 64'(0));
    chk("bp_busy", 64'(bus.busy), 64'(1));
    drain();
    // Grant hold with gappy valids.
    run_phase(4'b1001, 3, 4, 4, 40, 100, 60);
    drain();

    // Asynchronous reset during beat 2 of a ch1 packet.
    run_phase(4'b0010, 1, 4, 4, 100, 100, 0);
    for (int c = 0; c < 20 && beat_no[1] < 1; c++) cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    clear_tb_state();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(4'b0011, 1, 1, 2, 100, 100, 10);
    drain();

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      run_phase(N'($urandom_range(15, 1)), int'($urandom_range(4, 1)), 1, int'($urandom_range(6, 1)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 150);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
